subtree_status_collector: RTL and testbench

Upward-direction companion to the generated root/sub-module hierarchy: where each parent fans out to five child instances, this block gathers status words from those five children and returns them to the parent over a single stream. Children are served round-robin, each accepted word is tagged with its source index, and words are held in a small first-word-fall-through FIFO toward the parent. One collector sits at each hierarchy node that needs child-to-parent reporting.

---
 rtl/subtree_status_collector.sv | 100 ++++++++++
 tb/tb_subtree_status_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtree_status_collector.sv
// Gathers status words from child nodes round-robin and streams them,
// tagged with their source index, to the parent through a small FWFT FIFO.
module subtree_status_collector #(
  parameter  int N_CHILD    = 5,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int SRC_W      = $clog2(N_CHILD),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CHILD-1:0]        child_valid,
  input  logic [N_CHILD*DATA_W-1:0] child_data,
  output logic [N_CHILD-1:0]        child_ready,
  output logic                      up_valid,
  output logic [DATA_W-1:0]         up_data,
  output logic [SRC_W-1:0]          up_src,
  input  logic                      up_ready,
  output logic [CNT_W-1:0]          fifo_count,
  output logic                      drop_seen
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = SRC_W + DATA_W;

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               full;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  grant_data;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [ENT_W-1:0]   head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [N_CHILD-1:0] pending_q;

  // Scan children starting at rr_ptr, wrapping at N_CHILD.
  always_comb begin : arb
    int j;
    logic [SRC_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    idx       = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_CHILD) j = j - N_CHILD;
      idx = SRC_W'(j);
      if (!grant_any && child_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push       = grant_any && !full;
  assign up_valid   = (fifo_count != '0);
  assign pop        = up_valid && up_ready;
  assign grant_data = child_data[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    child_ready = '0;
    if (push) child_ready[grant_idx] = 1'b1;
  end

  assign head    = mem[rd_ptr];
  assign up_data = up_valid ? head[DATA_W-1:0] : '0;
  assign up_src  = up_valid ? head[DATA_W +: SRC_W] : '0;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {grant_idx, grant_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pending_q  <= '0;
      drop_seen  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (grant_idx == SRC_W'(N_CHILD - 1)) rr_ptr <= '0;
        else rr_ptr <= grant_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      // A child waiting without acceptance must keep valid high.
      pending_q <= child_valid & ~child_ready;
      if (|(pending_q & ~child_valid)) drop_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_subtree_status_collector.sv
// Scoreboard bench for subtree_status_collector: directed stimulus pushes
// expected words; a negedge monitor pops and compares delivered words.
module tb_subtree_status_collector;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int CW = 3;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    child_valid;
  logic [N*DW-1:0] child_data;
  logic [N-1:0]    child_ready;
  logic            up_valid;
  logic [DW-1:0]   up_data;
  logic [SW-1:0]   up_src;
  logic            up_ready;
  logic [CW-1:0]   fifo_count;
  logic            drop_seen;

  word_t       exp_q[$];
  word_t       mw;
  logic [7:0]  rw [20];
  int          errors = 0;
  int          checks = 0;

  subtree_status_collector dut (
    .clk        (clk),
    .rst        (rst),
    .child_valid(child_valid),
    .child_data (child_data),
    .child_ready(child_ready),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_src     (up_src),
    .up_ready   (up_ready),
    .fifo_count (fifo_count),
    .drop_seen  (drop_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [7:0] d);
    child_data[i*DW +: DW] = d;
  endtask

  task automatic expect_word(input int s, input logic [7:0] d);
    word_t w;
    w.src  = SW'(s);
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: a word is delivered when head valid meets up_ready out of reset.
  always @(negedge clk) begin
    if (!rst && up_valid && up_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got src=%0d data=%0h required none",
                 up_src, up_data);
      end else begin
        mw = exp_q.pop_front();
        chk("up_src", 32'(up_src), 32'(mw.src));
        chk("up_data", 32'(up_data), 32'(mw.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with all children valid.
    rst         = 1'b1;
    child_valid = '1;
    child_data  = '0;
    up_ready    = 1'b1;
    for (int i = 0; i < N; i++) setd(i, 8'(8'h10 + i));
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_up_valid", 32'(up_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_drop", 32'(drop_seen), 0);
    chk("rst_first_grant", 32'(child_ready), 32'h01);

    // Round-robin, one word per cycle.
    for (int k = 0; k < 10; k++) expect_word(k % 5, 8'(8'h10 + k % 5));
    for (int c = 1; c <= 10; c++) begin
      cyc();
      @(negedge clk);
      chk("rr_count", 32'(fifo_count), 1);
      chk("rr_up_valid", 32'(up_valid), 1);
    end
    cyc();
    rst         = 1'b1;
    child_valid = '0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(fifo_count), 0);
    chk("rr_drained", exp_q.size(), 0);

    // Full FIFO and backpressure with children 1 and 3.
    up_ready    = 1'b0;
    child_valid = 5'b01010;
    setd(1, 8'hA1);
    setd(3, 8'hA3);
    expect_word(1, 8'hA1);
    expect_word(3, 8'hA3);
    expect_word(1, 8'hA1);
    expect_word(3, 8'hA3);
    expect_word(1, 8'hA1);
    repeat (4) cyc();
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(child_ready), 0);
    cyc();
    up_ready = 1'b1;
    @(negedge clk);
    chk("full_hold_count", 32'(fifo_count), 4);
    cyc();
    up_ready = 1'b0;
    @(negedge clk);
    chk("full_pop_count", 32'(fifo_count), 3);
    chk("full_next_grant", 32'(child_ready), 32'h02);
    cyc();
    child_valid = '0;
    up_ready    = 1'b1;
    @(negedge clk);
    chk("refill_count", 32'(fifo_count), 4);
    repeat (4) cyc();
    @(negedge clk);
    chk("drain_count", 32'(fifo_count), 0);
    chk("full_drained", exp_q.size(), 0);
    rst = 1'b1;
    cyc();
    rst      = 1'b0;
    up_ready = 1'b0;

    // Simultaneous push/pop at count 2, FIFO order over 20 words.
    for (int k = 0; k < 20; k++) begin
      rw[k] = 8'($urandom_range(0, 255));
      expect_word(0, rw[k]);
    end
    child_valid = 5'b00001;
    setd(0, rw[0]);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k < 20) setd(0, rw[k]);
      else child_valid = '0;
      if (k == 2) up_ready = 1'b1;
      @(negedge clk);
      if (k >= 2) chk("pushpop_count", 32'(fifo_count), 2);
    end
    repeat (2) cyc();
    @(negedge clk);
    chk("pushpop_empty", 32'(fifo_count), 0);
    chk("pushpop_drained", exp_q.size(), 0);
    chk("pushpop_drop", 32'(drop_seen), 0);

    // Pointer skip: grant child 1, then only children 0 and 4.
    child_valid = 5'b00010;
    setd(1, 8'h31);
    expect_word(1, 8'h31);
    expect_word(4, 8'h34);
    expect_word(0, 8'h30);
    cyc();
    child_valid = 5'b10001;
    setd(0, 8'h30);
    setd(4, 8'h34);
    @(negedge clk);
    chk("skip_grant4", 32'(child_ready), 32'h10);
    cyc();
    child_valid = 5'b00001;
    @(negedge clk);
    chk("skip_grant0", 32'(child_ready), 32'h01);
    cyc();
    child_valid = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk("skip_drained", exp_q.size(), 0);
    chk("skip_drop", 32'(drop_seen), 0);

    // Child 2 drops valid while child 1 is granted.
    child_valid = 5'b00110;
    setd(1, 8'h41);
    setd(2, 8'h42);
    expect_word(1, 8'h41);
    cyc();
    child_valid = '0;
    @(negedge clk);
    chk("drop_before", 32'(drop_seen), 0);
    cyc();
    @(negedge clk);
    chk("drop_set", 32'(drop_seen), 1);
    repeat (3) cyc();
    @(negedge clk);
    chk("drop_sticky", 32'(drop_seen), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("drop_cleared", 32'(drop_seen), 0);
    chk("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
